// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the core's data-memory interface. Holds a word-organised
//   RAM and serves byte, half and word loads and stores. Each access waits a
//   configurable number of cycles before it completes. Loads return
//   sign- or zero-extended data with a one-cycle ready strobe. Misaligned and
//   out-of-range accesses are flagged and are not performed.
//
//   Ports
//     clk, rst_n     clock (rising edge), async active-low reset
//     dmem_req       access request, held by core until dmem_ready
//     dmem_wr        1 store, 0 load
//     dmem_size      2'b00 byte, 2'b01 half, 2'b10 word (2'b11 -> error)
//     dmem_zero_ex   load only: 1 zero-extend, 0 sign-extend
//     dmem_addr      byte address
//     dmem_wdata     store data, right-aligned
//     dmem_rdata     extended load data, valid while dmem_ready
//     dmem_ready     one-cycle completion strobe
//     dmem_err       with dmem_ready: misaligned / out-of-range, not performed
//
//   Byte-lane selection assumes 4-byte words (XLEN = 32).
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dmem_req,
    input  logic            dmem_wr,
    input  logic [1:0]      dmem_size,
    input  logic            dmem_zero_ex,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    output logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_ready,
    output logic            dmem_err
);

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state, state_nx;
    logic [3:0]      cnt;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic [1:0]      size_q;
    logic            wr_q, zx_q, err_q;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic            commit;
    logic            misaligned, in_range, acc_err;
    logic [XLEN-1:0] word_num;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] cur_word, wr_word, ld_data;
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (dmem_req) state_nx = S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;   // req still high here is not a new request
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_ready = (state == S_RESP);
        dmem_err   = (state == S_RESP) & err_q;
    end

    assign dmem_rdata = rdata_q;
    assign commit     = (state == S_WAIT) && (cnt == 4'd0);

    // ---------------------------------------------------------- decode
    // Full-width compare so high address bits can't alias into the RAM.
    assign word_num = {2'b00, addr_q[XLEN-1:2]};
    assign in_range = word_num < XLEN'(DEPTH_WORDS);
    assign idx      = addr_q[AW+1:2];
    assign cur_word = mem[idx];

    always_comb begin
        case (size_q)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_q[0];
            SZ_WORD: misaligned = |addr_q[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    assign acc_err   = misaligned | ~in_range;
    assign byte_lane = cur_word[{addr_q[1:0], 3'b000} +: 8];
    assign half_lane = addr_q[1] ? cur_word[31:16] : cur_word[15:0];

    always_comb begin
        ld_data = cur_word;
        case (size_q)
            SZ_BYTE: ld_data = {{(XLEN-8){~zx_q & byte_lane[7]}}, byte_lane};
            SZ_HALF: ld_data = {{(XLEN-16){~zx_q & half_lane[15]}}, half_lane};
            default: ld_data = cur_word;
        endcase
    end

    // Read-modify-write merge: only the addressed lane changes.
    always_comb begin
        wr_word = cur_word;
        case (size_q)
            SZ_BYTE: wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: begin
                if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
                else           wr_word[15:0]  = wdata_q[15:0];
            end
            default: wr_word = wdata_q;
        endcase
    end

    // -------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
            wr_q    <= 1'b0;
            zx_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (dmem_req) begin
                    addr_q  <= dmem_addr;
                    wdata_q <= dmem_wdata;
                    size_q  <= dmem_size;
                    wr_q    <= dmem_wr;
                    zx_q    <= dmem_zero_ex;
                    cnt     <= WAIT_INIT;
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        err_q   <= acc_err;
                        rdata_q <= (acc_err || wr_q) ? '0 : ld_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM is not reset. Reset forces state to IDLE asynchronously, so an
    // aborted store can never reach its commit edge.
    always_ff @(posedge clk) begin
        if (commit && wr_q && !acc_err) mem[idx] <= wr_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  req, wr, zx, ready, err;
    logic [1:0]  size  [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];

    int ws [3] = '{0, 1, 3};

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .dmem_req(req[0]), .dmem_wr(wr[0]),
        .dmem_size(size[0]), .dmem_zero_ex(zx[0]), .dmem_addr(addr[0]),
        .dmem_wdata(wdata[0]), .dmem_rdata(rdata[0]), .dmem_ready(ready[0]),
        .dmem_err(err[0]));
    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .dmem_req(req[1]), .dmem_wr(wr[1]),
        .dmem_size(size[1]), .dmem_zero_ex(zx[1]), .dmem_addr(addr[1]),
        .dmem_wdata(wdata[1]), .dmem_rdata(rdata[1]), .dmem_ready(ready[1]),
        .dmem_err(err[1]));
    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u2 (
        .clk(clk), .rst_n(rst_n), .dmem_req(req[2]), .dmem_wr(wr[2]),
        .dmem_size(size[2]), .dmem_zero_ex(zx[2]), .dmem_addr(addr[2]),
        .dmem_wdata(wdata[2]), .dmem_rdata(rdata[2]), .dmem_ready(ready[2]),
        .dmem_err(err[2]));

    typedef struct {
        string       tag;
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb [$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per ready strobe.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (ready[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_ready u%0d: got ready=1 want 0 (cyc %0d)", i, cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, ".inst"},    32'(i),   32'(e.inst));
                    chk({e.tag, ".rdata"},   rdata[i], e.rdata);
                    chk({e.tag, ".err"},     32'(err[i]), 32'(e.err));
                    chk({e.tag, ".latency"}, 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Issue one access in the next IDLE cycle and wait for its response.
    // hold keeps req high through RESP (must not start a new access).
    task automatic issue(int i, string tag, logic w, logic [1:0] sz, logic z,
                         logic [31:0] a, logic [31:0] d,
                         logic [31:0] er, logic ee, logic hold);
        exp_t e;
        bit   got;
        @(negedge clk);
        req[i] = 1'b1; wr[i] = w; size[i] = sz; zx[i] = z; addr[i] = a; wdata[i] = d;
        @(posedge clk);
        #1;
        e.tag = tag; e.inst = i; e.rdata = er; e.err = ee; e.cyc = cyc + 1 + ws[i];
        sb.push_back(e);
        // Latched inputs must not be affected by later changes.
        wr[i] = ~w; size[i] = ~sz; zx[i] = ~z; addr[i] = ~a; wdata[i] = ~d;
        got = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0 && !hold) req[i] = 1'b0;
            if (ready[i] === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL %s.timeout: got no ready want ready", tag);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; wr = '0; zx = '0;
        for (int i = 0; i < 3; i++) begin
            size[i] = W; addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 32'(ready), 32'd0);
        chk("rst.err",   32'(err),   32'd0);
        for (int i = 0; i < 3; i++) chk("rst.rdata", rdata[i], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // WAIT_STATES=1: basic word path
        issue(1, "sw10",   1, W, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        issue(1, "lw10",   0, W, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
        // byte store / load / extension
        issue(1, "sw100",  1, W, 0, 32'h100, 32'h0, 32'h0, 0, 0);
        issue(1, "sb101",  1, B, 0, 32'h101, 32'h777777A5, 32'h0, 0, 0);
        issue(1, "lw100a", 0, W, 0, 32'h100, 32'h0, 32'h0000A500, 0, 0);
        issue(1, "lb101",  0, B, 0, 32'h101, 32'h0, 32'hFFFFFFA5, 0, 0);
        issue(1, "lbu101", 0, B, 1, 32'h101, 32'h0, 32'h000000A5, 0, 0);
        // half store / load / misalignment
        issue(1, "sh102",  1, H, 0, 32'h102, 32'h12348001, 32'h0, 0, 0);
        issue(1, "lh102",  0, H, 0, 32'h102, 32'h0, 32'hFFFF8001, 0, 0);
        issue(1, "lhu102", 0, H, 1, 32'h102, 32'h0, 32'h00008001, 0, 0);
        issue(1, "sh103",  1, H, 0, 32'h103, 32'h0000FFFF, 32'h0, 1, 0);
        issue(1, "lw100b", 0, W, 0, 32'h100, 32'h0, 32'h8001A500, 0, 0);
        issue(1, "lh100",  0, H, 0, 32'h100, 32'h0, 32'hFFFFA500, 0, 0);
        issue(1, "lb103",  0, B, 0, 32'h103, 32'h0, 32'hFFFFFF80, 0, 0);
        issue(1, "lw102",  0, W, 0, 32'h102, 32'h0, 32'h0, 1, 0);
        issue(1, "lwzx",   0, W, 1, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
        // range boundary
        issue(1, "sw0",    1, W, 0, 32'h0, 32'h11111111, 32'h0, 0, 0);
        issue(1, "swlast", 1, W, 0, 32'hFFC, 32'h22222222, 32'h0, 0, 0);
        issue(1, "lwlast", 0, W, 0, 32'hFFC, 32'h0, 32'h22222222, 0, 0);
        issue(1, "lwoor",  0, W, 0, 32'h1000, 32'h0, 32'h0, 1, 0);
        issue(1, "swoor",  1, W, 0, 32'h1000, 32'hBADBADBA, 32'h0, 1, 0);
        issue(1, "sbhi",   1, B, 0, 32'h80000000, 32'h0000005A, 32'h0, 1, 0);
        issue(1, "lw0chk", 0, W, 0, 32'h0, 32'h0, 32'h11111111, 0, 0);
        issue(1, "lwlchk", 0, W, 0, 32'hFFC, 32'h0, 32'h22222222, 0, 0);
        issue(1, "swrd0",  1, W, 0, 32'h8, 32'h1, 32'h0, 0, 0);

        // WAIT_STATES=0 with req held across RESP
        issue(0, "ws0sw",  1, W, 0, 32'h40, 32'h0000000A, 32'h0, 0, 1);
        issue(0, "ws0lw",  0, W, 0, 32'h40, 32'h0, 32'h0000000A, 0, 1);
        issue(0, "ws0lb",  0, B, 0, 32'h40, 32'h0, 32'h0000000A, 0, 0);

        // WAIT_STATES=3
        issue(2, "ws3sw",  1, W, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, 1);
        issue(2, "ws3lw",  0, W, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0);

        // Reset in the 2nd WAIT cycle aborts a store
        @(negedge clk);
        req[2] = 1'b1; wr[2] = 1'b1; size[2] = W; zx[2] = 1'b0;
        addr[2] = 32'h20; wdata[2] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);          // 1st WAIT cycle
        req[2] = 1'b0;
        @(negedge clk);          // 2nd WAIT cycle
        rst_n = 1'b0;
        #1;
        chk("abort.rdata", rdata[2], 32'h0);
        chk("abort.ready", 32'(ready[2]), 32'h0);
        chk("abort.err",   32'(err[2]),   32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(2, "ws3post", 0, W, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0);

        repeat (8) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
